neander_mem_arbiter: RTL and testbench

Shares the single synchronous-read RAM between the NEANDER-X CPU and a debug/program-loader port. CPU requests come from the control unit's memory strobes; debug requests use a level req/ack handshake. The arbiter freezes the CPU with `cpu_hold` while the debug port owns the RAM, and re-reads the CPU's last address on release so that a held fetch or read sees valid data. It sits between the CPU core and the RAM macro in the top level.

---
 rtl/neander_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_neander_mem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/neander_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : neander_mem_arbiter
// Brief   : Shares one synchronous-read RAM between the NEANDER-X CPU and a
//           debug/program-loader port; freezes the CPU while debug owns it.
// Rev     : 1.0  initial release
// ============================================================================
module neander_mem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hold,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic              dbg_lock,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [2:0] S_CPU      = 3'd0;
    localparam logic [2:0] S_DBG_ADDR = 3'd1;
    localparam logic [2:0] S_DBG_DATA = 3'd2;
    localparam logic [2:0] S_LOCKED   = 3'd3;
    localparam logic [2:0] S_REPLAY   = 3'd4;

    localparam logic [7:0] C_STARVE_MAX = 8'(STARVE_LIMIT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [7:0]        r_starve_cnt;
    logic [7:0]        w_starve_nxt;
    logic [ADDR_W-1:0] r_last_addr;
    logic              w_pend;
    logic              w_cpu_yield;

    assign w_pend      = dbg_req | dbg_lock;
    // The CPU gives up the port when idle or once it has starved debug long enough.
    assign w_cpu_yield = !cpu_req || (r_starve_cnt == C_STARVE_MAX);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CPU: begin
                if (dbg_req && w_cpu_yield)
                    w_state_nxt = S_DBG_ADDR;
                else if (dbg_lock && w_cpu_yield)
                    w_state_nxt = S_LOCKED;
            end
            S_DBG_ADDR: w_state_nxt = S_DBG_DATA;
            S_DBG_DATA: w_state_nxt = dbg_lock ? S_LOCKED : S_REPLAY;
            S_LOCKED: begin
                if (dbg_req)
                    w_state_nxt = S_DBG_ADDR;
                else if (!dbg_lock)
                    w_state_nxt = S_REPLAY;
            end
            S_REPLAY: w_state_nxt = S_CPU;
            default:  w_state_nxt = S_CPU;
        endcase
    end

    always_comb begin
        w_starve_nxt = 8'd0;
        if (r_state == S_CPU && w_state_nxt == S_CPU && w_pend)
            w_starve_nxt = cpu_req ? r_starve_cnt + 8'd1 : r_starve_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_CPU;
            r_starve_cnt <= 8'd0;
            r_last_addr  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            if (r_state == S_CPU && cpu_req)
                r_last_addr <= cpu_addr;
        end
    end

    // RAM port mux; idle cycles keep the debug address/data on the bus.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = dbg_addr;
        ram_wdata = dbg_wdata;
        case (r_state)
            S_CPU: begin
                ram_en    = cpu_req;
                ram_we    = cpu_req & cpu_we;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
            end
            S_DBG_ADDR: begin
                ram_en = 1'b1;
                ram_we = dbg_we;
            end
            S_REPLAY: begin
                ram_en   = 1'b1;
                ram_addr = r_last_addr;
            end
            default: begin
                ram_en = 1'b0;
            end
        endcase
    end

    assign cpu_hold  = (r_state != S_CPU);
    assign dbg_ack   = (r_state == S_DBG_DATA);
    assign cpu_rdata = ram_rdata;
    assign dbg_rdata = ram_rdata;

endmodule
`default_nettype wire

// File: tb/tb_neander_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_neander_mem_arbiter
// Brief   : Self-checking bench with a RAM model and a debug-read scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_neander_mem_arbiter;

    typedef struct packed {
        logic       we;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [7:0] cpu_rdata, dbg_rdata, ram_addr, ram_wdata;
    logic [7:0] ram_rdata = 8'h00;
    logic       cpu_hold, dbg_ack, ram_en, ram_we;

    logic [7:0] ram_mem [256];
    logic [7:0] ref_mem [256];
    logic       ram_ready = 1'b0;
    exp_t       sb_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         lat;

    always #5 clk = ~clk;

    neander_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Synchronous-read RAM model, contents seeded on the first clock edge.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= 8'(i) ^ 8'h5A;
            ram_mem[8'h20] <= 8'h3C;
            ram_mem[8'h50] <= 8'h99;
            ram_ready <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_dbg(input logic we, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        e.we = we;
        e.data = we ? d : ref_mem[a];
        if (we) ref_mem[a] = d;
        sb_q.push_back(e);
    endtask

    // Returns in the ack cycle with dbg_req already dropped.
    task automatic dbg_xfer(input logic we, input logic [7:0] a, input logic [7:0] d,
                            output int n);
        start_dbg(we, a, d);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!dbg_ack && n < 40);
        check("ack_seen", dbg_ack, 1);
        dbg_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && dbg_ack) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_ack", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (!e.we) check("dbg_rdata", dbg_rdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
        ref_mem[8'h20] = 8'h3C;
        ref_mem[8'h50] = 8'h99;
        repeat (3) cyc();
        check("rst_hold", cpu_hold, 0);
        check("rst_ack", dbg_ack, 0);
        check("rst_ram_en", ram_en, 0);
        rst_n = 1'b1;
        cyc();

        // Idle-CPU debug write then read back
        start_dbg(1'b1, 8'h10, 8'hA5);
        #1 check("wr_t0_hold", cpu_hold, 0);
        cyc();
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 8'h10);
        check("wr_ram_wdata", ram_wdata, 8'hA5);
        cyc();
        check("wr_ack", dbg_ack, 1);
        dbg_req = 1'b0;
        cyc();
        check("wr_replay_en", ram_en, 1);
        check("wr_replay_we", ram_we, 0);
        check("wr_replay_hold", cpu_hold, 1);
        cyc();
        check("wr_resume_hold", cpu_hold, 0);
        dbg_xfer(1'b0, 8'h10, 8'h00, lat);
        check("rd_latency", lat, 2);
        repeat (2) cyc();

        // Starvation with busy CPU reading 0x20, then replay of that address
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h20;
        start_dbg(1'b0, 8'h50, 8'h00);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            check("starve_no_hold", cpu_hold, 0);
        end
        cyc();
        check("starve_preempt_hold", cpu_hold, 1);
        check("starve_dbg_addr", ram_addr, 8'h50);
        cyc();
        check("starve_ack", dbg_ack, 1);
        dbg_req = 1'b0;
        cyc();
        check("replay_addr", ram_addr, 8'h20);
        check("replay_en", ram_en, 1);
        check("replay_we", ram_we, 0);
        check("replay_hold", cpu_hold, 1);
        cyc();
        check("replay_resume_hold", cpu_hold, 0);
        check("replay_cpu_rdata", cpu_rdata, 8'h3C);
        cpu_req = 1'b0;
        cyc();

        // Lock-mode program load; first access has req and lock together
        dbg_lock = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dbg_xfer(1'b1, 8'h60 + 8'(i), 8'(i), lat);
            check("lock_latency", lat, 2);
            cyc();
            check("lock_hold", cpu_hold, 1);
            check("lock_ram_en", ram_en, 0);
        end
        dbg_lock = 1'b0;
        cyc();
        check("lock_replay_en", ram_en, 1);
        check("lock_replay_we", ram_we, 0);
        check("lock_replay_addr", ram_addr, 8'h20);
        cyc();
        check("lock_release_hold", cpu_hold, 0);
        dbg_xfer(1'b0, 8'h60, 8'h00, lat);
        repeat (2) cyc();
        dbg_xfer(1'b0, 8'h67, 8'h00, lat);
        repeat (2) cyc();

        // Async reset in the middle of a debug write
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h70; dbg_wdata = 8'hEE;
        cyc();
        check("mid_rst_pre_we", ram_we, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_hold", cpu_hold, 0);
        check("mid_rst_ack", dbg_ack, 0);
        dbg_req = 1'b0; dbg_we = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        check("post_rst_hold", cpu_hold, 0);
        dbg_xfer(1'b0, 8'h70, 8'h00, lat);
        check("post_rst_latency", lat, 2);
        repeat (3) cyc();

        check("sb_drain", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
